tbuf_alloc_sched: RTL and testbench

TBUF_ALLOC_SCHED -- requirements
Module: tbuf_alloc_sched

---
 rtl/tbuf_alloc_sched_pkg.sv | 17 +
 rtl/tbuf_rr_arb2.sv | 47 ++++
 rtl/tbuf_alloc_sched.sv | 184 ++++++++++++++++++
 tb/tb_tbuf_alloc_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbuf_alloc_sched_pkg.sv
// rtl/tbuf_alloc_sched_pkg.sv - shared types and defaults for the tag-buffer allocation scheduler
//
// Holds the scheduler FSM state type, the default CAM address width and the
// default saturation value of the stall counter.

package tbuf_alloc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FLUSH = 2'd2
  } tbuf_state_e;

  localparam int TBUF_WIDTH_DEF     = 11;
  localparam int TBUF_STALL_MAX_DEF = 255;

endpackage

// File: rtl/tbuf_rr_arb2.sv
// rtl/tbuf_rr_arb2.sv - two-requester round-robin arbiter with registered pointer
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointer favours requester 0)
//   req_i[1:0] : request per requester
//   en_i       : grant permitted this cycle; pointer only moves when a grant is issued
//   gnt_o[1:0] : one-hot grant (zero when nothing granted)
//   gnt_idx_o  : index of the granted requester (valid when gnt_o != 0)

module tbuf_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  // ptr_q names the requester that wins when both are asking.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    ptr_d     = ptr_q;
    if (en_i && (req_i != 2'b00)) begin
      if (req_i == 2'b11) begin
        gnt_idx_o = ptr_q;
      end else begin
        gnt_idx_o = req_i[1];
      end
      gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
      // The loser of this grant (or the idle requester) is favoured next time.
      ptr_d = ~gnt_idx_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tbuf_alloc_sched.sv
// rtl/tbuf_alloc_sched.sv - two-thread insert scheduler in front of an address CAM
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready[1:0]     : per-thread insert handshake (index = thread)
//   req_addr0, req_addr1         : insert address for thread 0 / thread 1
//   done, done_thread, done_dup  : completion pulse, its thread, address already present
//   flush_req, flush_thread      : one-cycle exception request for a thread
//   lk_addr, lk_valid, lk_hit    : external lookup port, lk_hit registered
//   cam_new_addr/_thread/_en     : CAM write of the held request
//   cam_chk_addr0, cam_chk_match0: duplicate check of the held address
//   cam_chk_addr1, cam_chk_match1: lookup check
//   cam_free                     : a free CAM entry exists for cam_new_thread
//   cam_except, cam_except_thread: exception notification, one cycle after flush_req
//   stall_cnt                    : cycles the held request has waited for a free entry

module tbuf_alloc_sched
  import tbuf_alloc_sched_pkg::*;
#(
  parameter int WIDTH     = TBUF_WIDTH_DEF,
  parameter int STALL_MAX = TBUF_STALL_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_addr0,
  input  logic [WIDTH-1:0] req_addr1,
  output logic             done,
  output logic             done_thread,
  output logic             done_dup,
  input  logic             flush_req,
  input  logic             flush_thread,
  input  logic [WIDTH-1:0] lk_addr,
  input  logic             lk_valid,
  output logic             lk_hit,
  output logic [WIDTH-1:0] cam_new_addr,
  output logic             cam_new_thread,
  output logic             cam_new_en,
  output logic [WIDTH-1:0] cam_chk_addr0,
  output logic [WIDTH-1:0] cam_chk_addr1,
  input  logic             cam_chk_match0,
  input  logic             cam_chk_match1,
  input  logic             cam_free,
  output logic             cam_except,
  output logic             cam_except_thread,
  output logic [7:0]       stall_cnt
);

  localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);

  tbuf_state_e      state_q, state_d;
  logic [WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic             hold_thread_q, hold_thread_d;
  // hold_valid_q tells FLUSH whether a request survives to go back to CHECK.
  logic             hold_valid_q, hold_valid_d;
  logic [7:0]       stall_q, stall_d;
  logic             fl_thread_q, fl_thread_d;
  logic             except_q, except_d;
  logic             except_thread_q, except_thread_d;
  logic             lk_hit_q, lk_hit_d;

  logic             arb_en;
  logic [1:0]       arb_gnt;
  logic             arb_idx;

  tbuf_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .en_i      (arb_en),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign cam_chk_addr0     = hold_addr_q;
  assign cam_new_addr      = hold_addr_q;
  assign cam_new_thread    = hold_thread_q;
  assign cam_chk_addr1     = lk_addr;
  assign lk_hit            = lk_hit_q;
  assign cam_except        = except_q;
  assign cam_except_thread = except_thread_q;
  assign stall_cnt         = stall_q;
  assign lk_hit_d          = lk_valid & cam_chk_match1;

  always_comb begin
    state_d         = state_q;
    hold_addr_d     = hold_addr_q;
    hold_thread_d   = hold_thread_q;
    hold_valid_d    = hold_valid_q;
    stall_d         = stall_q;
    fl_thread_d     = fl_thread_q;
    except_d        = 1'b0;
    except_thread_d = 1'b0;
    arb_en          = 1'b0;
    req_ready       = 2'b00;
    done            = 1'b0;
    done_dup        = 1'b0;
    done_thread     = 1'b0;
    cam_new_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A flush in IDLE suppresses the grant and leaves the pointer alone.
        arb_en    = !flush_req && !rst;
        req_ready = arb_gnt;
        if (arb_gnt != 2'b00) begin
          hold_addr_d   = arb_idx ? req_addr1 : req_addr0;
          hold_thread_d = arb_idx;
          hold_valid_d  = 1'b1;
          stall_d       = 8'd0;
          state_d       = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!flush_req && !rst) begin
          if (cam_chk_match0) begin
            done         = 1'b1;
            done_dup     = 1'b1;
            done_thread  = hold_thread_q;
            hold_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else if (cam_free) begin
            done         = 1'b1;
            done_thread  = hold_thread_q;
            cam_new_en   = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else if (stall_q != STALL_MAX_C) begin
            stall_d = stall_q + 8'd1;
          end
        end
      end

      ST_FLUSH: begin
        if (hold_valid_q && (hold_thread_q == fl_thread_q)) begin
          hold_valid_d = 1'b0;
        end
        if (hold_valid_d) begin
          stall_d = 8'd0;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Flush overrides whatever the state logic chose.
    if (flush_req) begin
      state_d         = ST_FLUSH;
      except_d        = 1'b1;
      except_thread_d = flush_thread;
      fl_thread_d     = flush_thread;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      hold_addr_q     <= '0;
      hold_thread_q   <= 1'b0;
      hold_valid_q    <= 1'b0;
      stall_q         <= 8'd0;
      fl_thread_q     <= 1'b0;
      except_q        <= 1'b0;
      except_thread_q <= 1'b0;
      lk_hit_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_addr_q     <= hold_addr_d;
      hold_thread_q   <= hold_thread_d;
      hold_valid_q    <= hold_valid_d;
      stall_q         <= stall_d;
      fl_thread_q     <= fl_thread_d;
      except_q        <= except_d;
      except_thread_q <= except_thread_d;
      lk_hit_q        <= lk_hit_d;
    end
  end

endmodule

// File: tb/tb_tbuf_alloc_sched.sv
// tb/tb_tbuf_alloc_sched.sv - self-checking bench for tbuf_alloc_sched

module tb_tbuf_alloc_sched;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_addr0, req_addr1;
  logic         done, done_thread, done_dup;
  logic         flush_req, flush_thread;
  logic [W-1:0] lk_addr;
  logic         lk_valid, lk_hit;
  logic [W-1:0] cam_new_addr;
  logic         cam_new_thread, cam_new_en;
  logic [W-1:0] cam_chk_addr0, cam_chk_addr1;
  logic         cam_chk_match0, cam_chk_match1, cam_free;
  logic         cam_except, cam_except_thread;
  logic [7:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tbuf_alloc_sched dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr0         (req_addr0),
    .req_addr1         (req_addr1),
    .done              (done),
    .done_thread       (done_thread),
    .done_dup          (done_dup),
    .flush_req         (flush_req),
    .flush_thread      (flush_thread),
    .lk_addr           (lk_addr),
    .lk_valid          (lk_valid),
    .lk_hit            (lk_hit),
    .cam_new_addr      (cam_new_addr),
    .cam_new_thread    (cam_new_thread),
    .cam_new_en        (cam_new_en),
    .cam_chk_addr0     (cam_chk_addr0),
    .cam_chk_addr1     (cam_chk_addr1),
    .cam_chk_match0    (cam_chk_match0),
    .cam_chk_match1    (cam_chk_match1),
    .cam_free          (cam_free),
    .cam_except        (cam_except),
    .cam_except_thread (cam_except_thread),
    .stall_cnt         (stall_cnt)
  );

  typedef struct {
    logic         rst;
    logic [1:0]   rv;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic         m0;
    logic         fr;
    logic         lkv;
    logic         m1;
    logic [1:0]   e_rdy;
    logic         e_done;
    logic         e_dup;
    logic         e_dthr;
    logic         e_nen;
    logic         e_lk;
    logic [W-1:0] e_addr;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    req_valid      = 2'b00;
    req_addr0      = '0;
    req_addr1      = '0;
    flush_req      = 1'b0;
    flush_thread   = 1'b0;
    lk_addr        = '0;
    lk_valid       = 1'b0;
    cam_chk_match0 = 1'b0;
    cam_chk_match1 = 1'b0;
    cam_free       = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Reference model state: "holding" a request, "flushing" cycle pending.
  logic         m_hold, m_thr, m_last, m_flushing, m_fthr, m_exc, m_exc_thr, m_lk;
  logic [W-1:0] m_addr;
  int           m_stall;

  task automatic model_reset();
    m_hold = 0; m_thr = 0; m_addr = '0; m_last = 1'b1; m_stall = 0;
    m_flushing = 0; m_fthr = 0; m_exc = 0; m_exc_thr = 0; m_lk = 0;
  endtask

  initial begin
    int n_done;
    logic [1:0] e_rdy;
    logic e_done, e_dup, e_dthr, e_nen, e_exc, e_exct, e_lk, g;
    int e_stall;

    rst = 1'b1;
    clr_inputs();
    next_cycle();
    next_cycle();

    // ---------------- table-driven vectors ----------------
    //          rst   rv    a0      a1      m0 fr lkv m1  rdy  dn dup dth nen lk addr
    tbl[0]  = '{1'b1, 2'b01, 11'h123, 11'h000, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 11'h000};
    tbl[1]  = '{1'b0, 2'b01, 11'h123, 11'h000, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 11'h000};
    tbl[2]  = '{1'b0, 2'b00, 11'h000, 11'h000, 0, 1, 1, 1, 2'b00, 1, 0, 0, 1, 0, 11'h123};
    tbl[3]  = '{1'b0, 2'b01, 11'h123, 11'h000, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 1, 11'h000};
    tbl[4]  = '{1'b0, 2'b00, 11'h000, 11'h000, 1, 1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 11'h123};
    tbl[5]  = '{1'b1, 2'b00, 11'h000, 11'h000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 11'h000};
    tbl[6]  = '{1'b0, 2'b11, 11'h010, 11'h020, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 11'h000};
    tbl[7]  = '{1'b0, 2'b11, 11'h010, 11'h020, 0, 1, 0, 0, 2'b00, 1, 0, 0, 1, 0, 11'h010};
    tbl[8]  = '{1'b0, 2'b11, 11'h010, 11'h020, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 11'h000};
    tbl[9]  = '{1'b0, 2'b11, 11'h010, 11'h020, 0, 1, 0, 0, 2'b00, 1, 0, 1, 1, 0, 11'h020};
    tbl[10] = '{1'b0, 2'b11, 11'h010, 11'h020, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 11'h000};
    tbl[11] = '{1'b0, 2'b11, 11'h010, 11'h020, 0, 1, 0, 0, 2'b00, 1, 0, 0, 1, 0, 11'h010};
    tbl[12] = '{1'b0, 2'b11, 11'h010, 11'h020, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 11'h000};
    tbl[13] = '{1'b0, 2'b11, 11'h010, 11'h020, 0, 1, 0, 0, 2'b00, 1, 0, 1, 1, 0, 11'h020};

    for (int i = 0; i < 14; i++) begin
      rst            = tbl[i].rst;
      req_valid      = tbl[i].rv;
      req_addr0      = tbl[i].a0;
      req_addr1      = tbl[i].a1;
      cam_chk_match0 = tbl[i].m0;
      cam_free       = tbl[i].fr;
      lk_valid       = tbl[i].lkv;
      cam_chk_match1 = tbl[i].m1;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_dup", i), 32'(done_dup), 32'(tbl[i].e_dup));
      chk($sformatf("tbl%0d_dthr", i), 32'(done_thread), 32'(tbl[i].e_dthr));
      chk($sformatf("tbl%0d_new_en", i), 32'(cam_new_en), 32'(tbl[i].e_nen));
      chk($sformatf("tbl%0d_lk_hit", i), 32'(lk_hit), 32'(tbl[i].e_lk));
      chk($sformatf("tbl%0d_except", i), 32'(cam_except), 32'd0);
      chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'd0);
      if (tbl[i].e_done) begin
        chk($sformatf("tbl%0d_new_addr", i), 32'(cam_new_addr), 32'(tbl[i].e_addr));
        chk($sformatf("tbl%0d_chk_addr0", i), 32'(cam_chk_addr0), 32'(tbl[i].e_addr));
        chk($sformatf("tbl%0d_new_thr", i), 32'(cam_new_thread), 32'(tbl[i].e_dthr));
      end
      next_cycle();
    end
    rst = 1'b0;

    // ---------------- stall saturation ----------------
    do_reset();
    req_valid = 2'b01; req_addr0 = 11'h055; cam_free = 1'b0;
    @(negedge clk);
    chk("stall_grant", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    n_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) chk("stall_entry_clear", 32'(stall_cnt), 32'd0);
      if (i == 10) chk("stall_count10", 32'(stall_cnt), 32'd10);
      if (done || cam_new_en || req_ready != 2'b00) n_done++;
      next_cycle();
    end
    chk("stall_no_done", 32'(n_done), 32'd0);
    cam_free = 1'b1;
    @(negedge clk);
    chk("stall_sat", 32'(stall_cnt), 32'd255);
    chk("stall_release_done", 32'(done), 32'h1);
    chk("stall_release_new_en", 32'(cam_new_en), 32'h1);
    chk("stall_release_addr", 32'(cam_new_addr), 32'h055);
    next_cycle();
    @(negedge clk);
    chk("stall_after_done", 32'(done), 32'h0);
    next_cycle();

    // ---------------- flush of the held thread ----------------
    do_reset();
    req_valid = 2'b10; req_addr1 = 11'h0AA; cam_free = 1'b1;
    @(negedge clk);
    chk("fl1_grant", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = 2'b00; flush_req = 1'b1; flush_thread = 1'b1;
    @(negedge clk);
    chk("fl1_req_cycle_done", 32'(done), 32'h0);
    chk("fl1_req_cycle_new_en", 32'(cam_new_en), 32'h0);
    chk("fl1_req_cycle_except", 32'(cam_except), 32'h0);
    next_cycle();
    flush_req = 1'b0; flush_thread = 1'b0;
    @(negedge clk);
    chk("fl1_except", 32'(cam_except), 32'h1);
    chk("fl1_except_thr", 32'(cam_except_thread), 32'h1);
    chk("fl1_flush_done", 32'(done), 32'h0);
    chk("fl1_flush_new_en", 32'(cam_new_en), 32'h0);
    next_cycle();
    req_valid = 2'b01; req_addr0 = 11'h0BB;
    @(negedge clk);
    chk("fl1_idle_after", 32'(req_ready), 32'h1);
    chk("fl1_except_once", 32'(cam_except), 32'h0);
    chk("fl1_dropped", 32'(done), 32'h0);
    next_cycle();

    // ---------------- flush of the other thread: request survives ----------------
    req_valid = 2'b00; flush_req = 1'b1; flush_thread = 1'b1;
    @(negedge clk);
    chk("fl0_req_cycle_done", 32'(done), 32'h0);
    next_cycle();
    flush_req = 1'b0;
    @(negedge clk);
    chk("fl0_except", 32'(cam_except), 32'h1);
    chk("fl0_except_thr", 32'(cam_except_thread), 32'h1);
    chk("fl0_flush_done", 32'(done), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("fl0_done_after", 32'(done), 32'h1);
    chk("fl0_done_thr", 32'(done_thread), 32'h0);
    chk("fl0_addr_kept", 32'(cam_new_addr), 32'h0BB);
    next_cycle();

    // ---------------- flush in IDLE suppresses the grant ----------------
    req_valid = 2'b01; flush_req = 1'b1; flush_thread = 1'b0;
    @(negedge clk);
    chk("flidle_no_grant", 32'(req_ready), 32'h0);
    next_cycle();
    flush_req = 1'b0;
    @(negedge clk);
    chk("flidle_flush_no_grant", 32'(req_ready), 32'h0);
    chk("flidle_except_thr", 32'(cam_except_thread), 32'h0);
    chk("flidle_except", 32'(cam_except), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("flidle_grant_after", 32'(req_ready), 32'h1);
    next_cycle();

    // ---------------- randomized against the reference model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      req_valid      = 2'($urandom);
      req_addr0      = W'($urandom);
      req_addr1      = W'($urandom);
      cam_chk_match0 = ($urandom_range(0, 3) == 0);
      cam_free       = ($urandom_range(0, 2) != 0);
      flush_req      = ($urandom_range(0, 11) == 0);
      flush_thread   = 1'($urandom);
      lk_addr        = W'($urandom);
      lk_valid       = 1'($urandom);
      cam_chk_match1 = 1'($urandom);

      e_exc = m_exc; e_exct = m_exc_thr; e_stall = m_stall; e_lk = m_lk;
      e_rdy = 2'b00; e_done = 0; e_dup = 0; e_dthr = 0; e_nen = 0;
      if (rst) begin
        model_reset();
      end else begin
        if (m_flushing) begin
          if (m_hold && m_thr == m_fthr) m_hold = 0;
          if (m_hold) m_stall = 0;
        end else if (!m_hold) begin
          if (!flush_req && req_valid != 2'b00) begin
            g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
            e_rdy = g ? 2'b10 : 2'b01;
            m_last = g; m_thr = g; m_hold = 1; m_stall = 0;
            m_addr = g ? req_addr1 : req_addr0;
          end
        end else if (!flush_req) begin
          if (cam_chk_match0) begin
            e_done = 1; e_dup = 1; e_dthr = m_thr; m_hold = 0;
          end else if (cam_free) begin
            e_done = 1; e_nen = 1; e_dthr = m_thr; m_hold = 0;
          end else if (m_stall < 255) begin
            m_stall++;
          end
        end
        m_flushing = flush_req;
        m_exc      = flush_req;
        m_exc_thr  = flush_req & flush_thread;
        if (flush_req) m_fthr = flush_thread;
        m_lk = lk_valid & cam_chk_match1;
      end

      @(negedge clk);
      chk("rnd_ready", 32'(req_ready), 32'(e_rdy));
      chk("rnd_done", 32'(done), 32'(e_done));
      chk("rnd_dup", 32'(done_dup), 32'(e_dup));
      chk("rnd_dthr", 32'(done_thread), 32'(e_dthr));
      chk("rnd_new_en", 32'(cam_new_en), 32'(e_nen));
      chk("rnd_except", 32'(cam_except), 32'(e_exc));
      chk("rnd_except_thr", 32'(cam_except_thread), 32'(e_exct));
      chk("rnd_stall", 32'(stall_cnt), 32'(e_stall));
      chk("rnd_lk_hit", 32'(lk_hit), 32'(e_lk));
      chk("rnd_chk_addr1", 32'(cam_chk_addr1), 32'(lk_addr));
      if (e_done) begin
        chk("rnd_new_addr", 32'(cam_new_addr), 32'(m_addr));
        chk("rnd_new_thr", 32'(cam_new_thread), 32'(e_dthr));
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
